dm_responder: RTL and testbench
===============================

// Module: dm_responder
// PURPOSE
//  Data-memory responder: the memory end of the load/store path driven by the CPU control.
//  Accepts one word read/write request at a time over a valid/ready handshake.
//  Returns the result after a fixed LATENCY, using valid/ready back-pressure.
//  Replaces the zero-latency data memory so the control path can be built and tested against wait states.
// PARAMETERS
//  DEPTH_WORDS  256  words of storage; power of 2, >=2; index = addr[$clog2(DEPTH_WORDS)+1:2]
//  LATENCY      2    cycles from request accept to resp_valid; legal range 1..15
// PORTS
//  clk         in   1   clock, all state updates on posedge
//  rst         in   1   asynchronous, active-high reset
//  req_valid   in   1   request present
//  req_ready   out  1   responder can accept; high only in IDLE
//  req_write   in   1   1=store (sw), 0=load (lw)
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data
//  resp_valid  out  1   response present
//  resp_ready  in   1   requester takes response
//  resp_rdata  out  32  load data; for stores, echoes the stored word
//  resp_err    out  1   misaligned access (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, counter=0.
//    req_ready=1 once rst is low. Memory array is not reset.
//  - FSM states: IDLE, WAIT, RESP.
//    IDLE: req_ready=1. On req_valid at posedge: capture addr, write, wdata; cnt<=LATENCY-1; go to WAIT.
//    WAIT: req_ready=0. cnt==0 at posedge: perform access, load resp_rdata/resp_err, resp_valid<=1, go to RESP.
//          Otherwise cnt<=cnt-1.
//    RESP: req_ready=0, outputs held stable. On resp_ready at posedge: resp_valid<=0; go to IDLE.
//  - Latency: request accepted at edge E gives resp_valid high after edge E+LATENCY.
//    Minimum request-to-request spacing is LATENCY+2 cycles with resp_ready tied high.
//  - Store is committed to the array on the WAIT->RESP edge, never earlier.
//    A load captures the array word on that same edge.
//  - Index wrap: upper address bits above the index are ignored (address aliases modulo DEPTH_WORDS*4).
//  - req_valid during WAIT/RESP: ignored, no capture. The requester must hold the request until req_ready.
//  - resp_ready low in RESP: hold resp_valid, resp_rdata and resp_err indefinitely, with no timeout.
//  - resp_ready high outside RESP: no effect.
//  - rst asserted mid-transaction: abort immediately.
//    A store still in WAIT is discarded; a store already in RESP remains committed.
//  - resp_rdata/resp_err keep their last value in IDLE/WAIT (not cleared) until the next response.
// CONFIGURATION
//  DM_MISALIGN_CHECK_EN defined:
//    req_addr[1:0]!=0 makes the access a no-op (no array write).
//    The response then has resp_err=1 and resp_rdata=0, with the same latency/handshake.
//  DM_MISALIGN_CHECK_EN undefined:
//    req_addr[1:0] ignored (word-aligned access to the containing word); resp_err tied 0.
// TESTING
//  1 Reset: rst=1 mid-sim, async -> resp_valid=0, resp_rdata=0 without a clock edge.
//    After release -> req_ready=1.
//  2 Store/load, LATENCY=2: sw addr 0x0000_0010 data 0xDEAD_BEEF, then lw 0x10.
//    -> each resp_valid exactly 2 edges after accept; load resp_rdata=0xDEAD_BEEF.
//  3 Back-pressure: hold resp_ready=0 for 5 cycles.
//    -> resp_valid/resp_rdata stable all 5 cycles, req_ready=0; one cycle after resp_ready=1 -> req_ready=1.
//  4 Wrap, DEPTH_WORDS=256: sw 0x400 data 0x1234_5678, lw 0x0 -> rdata=0x1234_5678.
//  5 Reset mid-WAIT: sw 0x20 data 0xFFFF_FFFF, rst pulse 1 cycle after accept, then lw 0x20
//    -> old contents (bench preloads 0x0000_0000), no stray resp_valid.
//  6 With DM_MISALIGN_CHECK_EN: sw 0x22 data 0xAAAA_AAAA -> resp_err=1, resp_rdata=0.
//    lw 0x20 -> resp_err=0, word unchanged.
//    Without the macro: the same sw writes word 0x20 and resp_err=0.

Source files
------------

// File: rtl/dm_responder.sv
// Data-memory responder: one word load/store per valid/ready request, answered after LATENCY cycles.
// Optional build macro DM_MISALIGN_CHECK_EN turns misaligned accesses into no-ops that report resp_err.
module dm_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned IW = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          write_q, write_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          mis_q, mis_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          mem_we;
  logic          req_mis;

  logic [31:0]   mem_q [DEPTH_WORDS];

`ifdef DM_MISALIGN_CHECK_EN
  assign req_mis = (req_addr[1:0] != 2'b00);
`else
  assign req_mis = 1'b0;
`endif

  // Address bits outside the word index are deliberately ignored (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[31:IW+2], req_addr[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      mis_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      mis_q   <= mis_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is not reset; a store commits only on the WAIT->RESP edge.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    write_d = write_q;
    wdata_d = wdata_q;
    mis_d   = mis_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          idx_d   = req_addr[IW+1:2];
          write_d = req_write;
          wdata_d = req_wdata;
          mis_d   = req_mis;
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          if (mis_q) begin
            rdata_d = '0;
            err_d   = 1'b1;
          end else begin
            err_d = 1'b0;
            if (write_q) begin
              mem_we  = 1'b1;
              rdata_d = wdata_q;
            end else begin
              rdata_d = mem_q[idx_q];
            end
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: transaction-level timing/memory model checked every cycle, plus directed literals.
module tb_dm_responder;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned LAT   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_ready = 1'b0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  dm_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: a request accepted at edge E is answered at edge E+LAT and leaves at the first
  // later edge with resp_ready high; memory is a sparse map of known words.
  bit          m_busy = 0, m_rv = 0, m_known = 1, m_err = 0, m_w = 0;
  logic [31:0] m_rdata = '0, m_a = '0, m_d = '0;
  int          m_acc = 0, cyc = 0;
  logic [31:0] mem_m [int];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_rv = 0; m_rdata = '0; m_err = 0; m_known = 1;
    end else begin
      if (!m_busy) begin
        if (req_valid) begin
          m_busy = 1; m_acc = cyc; m_w = req_write; m_a = req_addr; m_d = req_wdata;
        end
      end else if (!m_rv) begin
        if (cyc == m_acc + int'(LAT)) begin
          int idx;
          idx = int'((m_a >> 2) % DEPTH);
          m_rv = 1;
`ifdef DM_MISALIGN_CHECK_EN
          if (m_a[1:0] != 2'b00) begin
            m_rdata = '0; m_err = 1; m_known = 1;
          end else
`endif
          begin
            m_err = 0;
            if (m_w) begin
              mem_m[idx] = m_d; m_rdata = m_d; m_known = 1;
            end else if (mem_m.exists(idx)) begin
              m_rdata = mem_m[idx]; m_known = 1;
            end else begin
              m_known = 0;
            end
          end
        end
      end else if (resp_ready) begin
        m_rv = 0; m_busy = 0;
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("req_ready", {31'b0, req_ready}, {31'b0, !m_busy});
      chk("resp_valid", {31'b0, resp_valid}, {31'b0, m_rv});
      chk("resp_err", {31'b0, resp_err}, {31'b0, m_err});
      if (m_known) chk("resp_rdata", resp_rdata, m_rdata);
    end
  end

  task automatic send(input bit w, input logic [31:0] a, input logic [31:0] d);
    int n;
    bit rdy;
    n = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    forever begin
      @(negedge clk); rdy = req_ready;
      @(posedge clk); #1;
      if (rdy) break;
      n++;
      if (n > 50) begin
        total++; bad++;
        $display("FAIL accept_timeout actual=stuck required=accept");
        break;
      end
    end
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
  endtask

  task automatic finish_resp(input int hold, output logic [31:0] rd, output logic er, output int lat);
    lat = 0;
    resp_ready = 1'($urandom);
    forever begin
      @(posedge clk); #1;
      lat++;
      if (resp_valid) break;
      resp_ready = 1'($urandom);
      if (lat > 40) begin
        total++; bad++;
        $display("FAIL resp_timeout actual=none required=resp_valid");
        break;
      end
    end
    rd = resp_rdata; er = resp_err;
    resp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'b0, resp_valid}, 32'd1);
      chk("hold_rdata", resp_rdata, rd);
      chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;

    #12 rst = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_req_ready", {31'b0, req_ready}, 32'd1);
    chk("post_reset_rdata", resp_rdata, 32'h0);

    // Store then load, fixed latency.
    send(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    finish_resp(0, rd, er, lat);
    chk("sw_latency", 32'(lat), 32'(LAT));
    chk("sw_echo", rd, 32'hDEAD_BEEF);
    send(1'b0, 32'h0000_0010, 32'h0);
    finish_resp(0, rd, er, lat);
    chk("lw_latency", 32'(lat), 32'(LAT));
    chk("lw_rdata", rd, 32'hDEAD_BEEF);

    // Back-pressure for 5 cycles.
    send(1'b0, 32'h0000_0010, 32'h0);
    finish_resp(5, rd, er, lat);
    chk("bp_rdata", rd, 32'hDEAD_BEEF);
    chk("bp_req_ready_after", {31'b0, req_ready}, 32'd1);

    // Index wrap.
    send(1'b1, 32'h0000_0400, 32'h1234_5678);
    finish_resp(0, rd, er, lat);
    send(1'b0, 32'h0000_0000, 32'h0);
    finish_resp(1, rd, er, lat);
    chk("wrap_rdata", rd, 32'h1234_5678);

    // Async reset while a store sits in RESP: outputs clear without an edge, store stays.
    send(1'b1, 32'h0000_0030, 32'h0000_0055);
    repeat (LAT) @(posedge clk);
    #1;
    chk("in_resp_valid", {31'b0, resp_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'b0, resp_valid}, 32'd0);
    chk("async_rst_rdata", resp_rdata, 32'h0);
    @(negedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_release_req_ready", {31'b0, req_ready}, 32'd1);
    send(1'b0, 32'h0000_0030, 32'h0);
    finish_resp(0, rd, er, lat);
    chk("resp_store_kept", rd, 32'h0000_0055);

    // Reset mid-WAIT discards the store.
    send(1'b1, 32'h0000_0020, 32'h0000_0000);
    finish_resp(0, rd, er, lat);
    send(1'b1, 32'h0000_0020, 32'hFFFF_FFFF);
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("no_stray_valid", {31'b0, resp_valid}, 32'd0);
    end
    @(posedge clk); #1;
    send(1'b0, 32'h0000_0020, 32'h0);
    finish_resp(0, rd, er, lat);
    chk("wait_store_discarded", rd, 32'h0000_0000);

    // Misaligned store.
    send(1'b1, 32'h0000_0022, 32'hAAAA_AAAA);
    finish_resp(0, rd, er, lat);
`ifdef DM_MISALIGN_CHECK_EN
    chk("mis_err", {31'b0, er}, 32'd1);
    chk("mis_rdata", rd, 32'h0);
`else
    chk("mis_err", {31'b0, er}, 32'd0);
    chk("mis_rdata", rd, 32'hAAAA_AAAA);
`endif
    send(1'b0, 32'h0000_0020, 32'h0);
    finish_resp(0, rd, er, lat);
    chk("mis_follow_err", {31'b0, er}, 32'd0);
`ifdef DM_MISALIGN_CHECK_EN
    chk("mis_word_unchanged", rd, 32'h0000_0000);
`else
    chk("mis_word_written", rd, 32'hAAAA_AAAA);
`endif

    // Randomized traffic over a small aliased window.
    for (int t = 0; t < 150; t++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 15) << 2) | ($urandom_range(0, 7) << 10);
      if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
      send(1'($urandom), a, $urandom);
      finish_resp(int'($urandom_range(0, 3)), rd, er, lat);
      chk("rand_latency", 32'(lat), 32'(LAT));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
